dmem_arbiter: RTL and testbench

- Two-requester arbiter and access formatter in front of the byte-banked data RAM (4 byte lanes, 1-cycle registered read).
- Port 0 is the core LSU; port 1 is the DMA/debug master.
- Per cycle it grants one requester and drives the RAM address, read/write, per-lane byte-enable and lane-aligned write data.
- It returns sign/zero-extended read data, or a write acknowledge, exactly one cycle after grant. Misaligned accesses are rejected without touching the RAM.

---
 rtl/dmem_pkg.sv | 54 +++++
 rtl/dmem_arb_core.sv | 68 ++++++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and access-formatting helpers for the data-memory arbiter.
package dmem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef struct packed {
        logic       valid;
        logic       port;
        logic [1:0] off;
        logic [2:0] size;
        logic       err;
        logic       is_load;
    } rsp_t;

    function automatic logic size_legal(logic [2:0] size, logic [1:0] off);
        case (size)
            SZ_B, SZ_BU: return 1'b1;
            SZ_H, SZ_HU: return ~off[0];
            SZ_W:        return off == 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(logic [2:0] size, logic [1:0] off);
        case (size)
            SZ_B, SZ_BU: return 4'b0001 << off;
            SZ_H, SZ_HU: return 4'b0011 << off;
            SZ_W:        return 4'b1111;
            default:     return 4'b0000;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend per access size.
    function automatic logic [31:0] load_extend(logic [2:0] size, logic [1:0] off,
                                                logic [31:0] dout);
        logic [31:0] sh;
        sh = dout >> {off, 3'b000};
        case (size)
            SZ_B:    return {{24{sh[7]}}, sh[7:0]};
            SZ_BU:   return {24'h0, sh[7:0]};
            SZ_H:    return {{16{sh[15]}}, sh[15:0]};
            SZ_HU:   return {16'h0, sh[15:0]};
            SZ_W:    return dout;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arb_core.sv
// Grant logic for the two data-memory requesters. DMEM_ARB_RR_EN selects
// round-robin with a bounded port-1 lock; otherwise port 0 has fixed priority.
module dmem_arb_core #(
    parameter int unsigned LOCK_MAX = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_p0_req,
    input  logic i_p1_req,
    input  logic i_p1_lock,
    output logic o_p0_gnt,
    output logic o_p1_gnt
);

`ifdef DMEM_ARB_RR_EN
    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    logic          ptr_q;
    logic          lock_q;
    logic [CW-1:0] cnt_q;
    logic          lock_win;

    // Once the lock count is exhausted, the pointer already faces port 0
    // (port 1 was granted last), so falling through to round-robin releases it.
    always_comb begin
        lock_win = lock_q && i_p1_req && (cnt_q != CW'(LOCK_MAX));
        o_p0_gnt = 1'b0;
        o_p1_gnt = 1'b0;
        if (!i_rst) begin
            if (lock_win) begin
                o_p1_gnt = 1'b1;
            end else if (i_p0_req && i_p1_req) begin
                o_p0_gnt = ~ptr_q;
                o_p1_gnt = ptr_q;
            end else begin
                o_p0_gnt = i_p0_req;
                o_p1_gnt = i_p1_req;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q  <= 1'b0;
            lock_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (o_p0_gnt) begin
                ptr_q <= 1'b1;
            end else if (o_p1_gnt) begin
                ptr_q <= 1'b0;
            end
            lock_q <= o_p1_gnt && i_p1_lock;
            cnt_q  <= (o_p1_gnt && lock_win) ? cnt_q + CW'(1) : '0;
        end
    end
`else
    localparam int unsigned unused_lock_max = LOCK_MAX;
    logic unused_ok;
    assign unused_ok = ^{i_clk, i_p1_lock};

    always_comb begin
        o_p0_gnt = i_p0_req && !i_rst;
        o_p1_gnt = i_p1_req && !i_p0_req && !i_rst;
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access formatter for the byte-banked data RAM.
// Define DMEM_ARB_RR_EN for round-robin + port-1 lock; default is fixed priority.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DMEM_ADDR_WIDTH = 12,
    parameter int unsigned LOCK_MAX        = 15
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_p0_req,
    input  logic                       i_p0_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] i_p0_addr,
    input  logic [2:0]                 i_p0_size,
    input  logic [31:0]                i_p0_wdata,
    output logic                       o_p0_gnt,
    output logic                       o_p0_rvalid,
    output logic [31:0]                o_p0_rdata,
    output logic                       o_p0_err,
    input  logic                       i_p1_req,
    input  logic                       i_p1_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] i_p1_addr,
    input  logic [2:0]                 i_p1_size,
    input  logic [31:0]                i_p1_wdata,
    input  logic                       i_p1_lock,
    output logic                       o_p1_gnt,
    output logic                       o_p1_rvalid,
    output logic [31:0]                o_p1_rdata,
    output logic                       o_p1_err,
    output logic [DMEM_ADDR_WIDTH-1:0] o_ram_addr,
    output logic                       o_ram_read,
    output logic                       o_ram_write,
    output logic [3:0]                 o_ram_size,
    output logic [31:0]                o_ram_din,
    input  logic [31:0]                i_ram_dout
);

    logic                       gnt0;
    logic                       gnt1;
    logic                       any_gnt;
    logic                       sel_we;
    logic [DMEM_ADDR_WIDTH-1:0] sel_addr;
    logic [2:0]                 sel_size;
    logic [31:0]                sel_wdata;
    logic [1:0]                 off;
    logic                       legal;
    logic [31:0]                fmt_din;
    logic [DMEM_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]                din_q;
    rsp_t                       rsp_d;
    rsp_t                       rsp_q;
    logic [31:0]                load_data;

    dmem_arb_core #(
        .LOCK_MAX (LOCK_MAX)
    ) u_core (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_p0_req  (i_p0_req),
        .i_p1_req  (i_p1_req),
        .i_p1_lock (i_p1_lock),
        .o_p0_gnt  (gnt0),
        .o_p1_gnt  (gnt1)
    );

    assign o_p0_gnt = gnt0;
    assign o_p1_gnt = gnt1;

    always_comb begin
        any_gnt   = gnt0 | gnt1;
        sel_we    = gnt1 ? i_p1_we    : i_p0_we;
        sel_addr  = gnt1 ? i_p1_addr  : i_p0_addr;
        sel_size  = gnt1 ? i_p1_size  : i_p0_size;
        sel_wdata = gnt1 ? i_p1_wdata : i_p0_wdata;
        off       = sel_addr[1:0];
        legal     = size_legal(sel_size, off);

        case (sel_size)
            SZ_B, SZ_BU: fmt_din = {4{sel_wdata[7:0]}};
            SZ_H, SZ_HU: fmt_din = {2{sel_wdata[15:0]}};
            default:     fmt_din = sel_wdata;
        endcase

        // Address and data hold between accesses; only the strobes drop.
        o_ram_addr  = any_gnt ? sel_addr : addr_q;
        o_ram_din   = any_gnt ? fmt_din  : din_q;
        o_ram_read  = any_gnt && legal && !sel_we;
        o_ram_write = any_gnt && legal && sel_we;
        o_ram_size  = (any_gnt && legal) ? byte_en(sel_size, off) : 4'b0000;

        rsp_d         = '0;
        rsp_d.valid   = any_gnt;
        rsp_d.port    = gnt1;
        rsp_d.off     = off;
        rsp_d.size    = sel_size;
        rsp_d.err     = !legal;
        rsp_d.is_load = !sel_we;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_q  <= '0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            rsp_q <= rsp_d;
            if (any_gnt) begin
                addr_q <= sel_addr;
                din_q  <= fmt_din;
            end
        end
    end

    always_comb begin
        load_data   = (rsp_q.is_load && !rsp_q.err) ?
                      load_extend(rsp_q.size, rsp_q.off, i_ram_dout) : 32'h0;
        o_p0_rvalid = rsp_q.valid && !rsp_q.port;
        o_p1_rvalid = rsp_q.valid && rsp_q.port;
        o_p0_err    = o_p0_rvalid && rsp_q.err;
        o_p1_err    = o_p1_rvalid && rsp_q.err;
        o_p0_rdata  = o_p0_rvalid ? load_data : 32'h0;
        o_p1_rdata  = o_p1_rvalid ? load_data : 32'h0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-banked RAM.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [11:0] p0_addr, p1_addr;
    logic [2:0]  p0_size, p1_size;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [11:0] ram_addr;
    logic        ram_read, ram_write;
    logic [3:0]  ram_size;
    logic [31:0] ram_din, ram_dout;
    logic [31:0] mem [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(.DMEM_ADDR_WIDTH(12), .LOCK_MAX(15)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr),
        .i_p0_size(p0_size), .i_p0_wdata(p0_wdata),
        .o_p0_gnt(p0_gnt), .o_p0_rvalid(p0_rvalid), .o_p0_rdata(p0_rdata), .o_p0_err(p0_err),
        .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr),
        .i_p1_size(p1_size), .i_p1_wdata(p1_wdata), .i_p1_lock(p1_lock),
        .o_p1_gnt(p1_gnt), .o_p1_rvalid(p1_rvalid), .o_p1_rdata(p1_rdata), .o_p1_err(p1_err),
        .o_ram_addr(ram_addr), .o_ram_read(ram_read), .o_ram_write(ram_write),
        .o_ram_size(ram_size), .o_ram_din(ram_din), .i_ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_read) ram_dout <= mem[ram_addr[11:2]];
        if (ram_write) begin
            for (int l = 0; l < 4; l++) begin
                if (ram_size[l]) mem[ram_addr[11:2]][8*l +: 8] <= ram_din[8*l +: 8];
            end
        end
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [11:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  en;
        logic [31:0] din;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic port, input logic we, input logic [11:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata);
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_size = size; p1_wdata = wdata;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_size = size; p0_wdata = wdata;
        end
    endtask

    task automatic idle();
        p0_req = 1'b0; p1_req = 1'b0; p1_lock = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vt[i];
        @(posedge clk); #1;
        drive(v.port, v.we, v.addr, v.size, v.wdata);
        #3;
        check($sformatf("v%0d gnt", i), 32'(v.port ? p1_gnt : p0_gnt), 32'd1);
        check($sformatf("v%0d other_gnt", i), 32'(v.port ? p0_gnt : p1_gnt), 32'd0);
        check($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(v.addr));
        check($sformatf("v%0d ram_read", i), 32'(ram_read), 32'(!v.we && !v.err));
        check($sformatf("v%0d ram_write", i), 32'(ram_write), 32'(v.we && !v.err));
        check($sformatf("v%0d ram_size", i), 32'(ram_size), 32'(v.en));
        if (v.we && !v.err) check($sformatf("v%0d ram_din", i), ram_din, v.din);
        @(posedge clk); #1;
        idle();
        #1;
        check($sformatf("v%0d rvalid", i), 32'(v.port ? p1_rvalid : p0_rvalid), 32'd1);
        check($sformatf("v%0d other_rvalid", i), 32'(v.port ? p0_rvalid : p1_rvalid), 32'd0);
        check($sformatf("v%0d err", i), 32'(v.port ? p1_err : p0_err), 32'(v.err));
        check($sformatf("v%0d rdata", i), v.port ? p1_rdata : p0_rdata, v.rdata);
        check($sformatf("v%0d idle_strobes", i), 32'({ram_read, ram_write, ram_size}), 32'd0);
        check($sformatf("v%0d idle_addr_hold", i), 32'(ram_addr), 32'(v.addr));
        if (v.we && !v.err) check($sformatf("v%0d idle_din_hold", i), ram_din, v.din);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        //          port  we    addr     size    wdata          en     din            err   rdata
        vt[0]  = '{1'b0, 1'b1, 12'h010, 3'b010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0, 32'h00000000};
        vt[1]  = '{1'b0, 1'b0, 12'h010, 3'b010, 32'h0,        4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
        vt[2]  = '{1'b0, 1'b0, 12'h013, 3'b000, 32'h0,        4'h8, 32'h0,        1'b0, 32'hFFFFFFDE};
        vt[3]  = '{1'b0, 1'b0, 12'h013, 3'b100, 32'h0,        4'h8, 32'h0,        1'b0, 32'h000000DE};
        vt[4]  = '{1'b0, 1'b0, 12'h012, 3'b001, 32'h0,        4'hC, 32'h0,        1'b0, 32'hFFFFDEAD};
        vt[5]  = '{1'b0, 1'b0, 12'h010, 3'b101, 32'h0,        4'h3, 32'h0,        1'b0, 32'h0000BEEF};
        vt[6]  = '{1'b0, 1'b1, 12'h011, 3'b000, 32'h00000055, 4'h2, 32'h55555555, 1'b0, 32'h00000000};
        vt[7]  = '{1'b0, 1'b0, 12'h010, 3'b010, 32'h0,        4'hF, 32'h0,        1'b0, 32'hDEAD55EF};
        vt[8]  = '{1'b0, 1'b0, 12'h012, 3'b010, 32'h0,        4'h0, 32'h0,        1'b1, 32'h00000000};
        vt[9]  = '{1'b0, 1'b1, 12'h011, 3'b001, 32'h00001234, 4'h0, 32'h0,        1'b1, 32'h00000000};
        vt[10] = '{1'b0, 1'b0, 12'h010, 3'b010, 32'h0,        4'hF, 32'h0,        1'b0, 32'hDEAD55EF};
        vt[11] = '{1'b0, 1'b1, 12'h012, 3'b001, 32'h1234A5C3, 4'hC, 32'hA5C3A5C3, 1'b0, 32'h00000000};
        vt[12] = '{1'b0, 1'b0, 12'h010, 3'b010, 32'h0,        4'hF, 32'h0,        1'b0, 32'hA5C355EF};
        vt[13] = '{1'b0, 1'b0, 12'h014, 3'b011, 32'h0,        4'h0, 32'h0,        1'b1, 32'h00000000};
        vt[14] = '{1'b0, 1'b0, 12'h010, 3'b000, 32'h0,        4'h1, 32'h0,        1'b0, 32'hFFFFFFEF};
        vt[15] = '{1'b0, 1'b0, 12'h012, 3'b101, 32'h0,        4'hC, 32'h0,        1'b0, 32'h0000A5C3};
        vt[16] = '{1'b1, 1'b0, 12'h010, 3'b010, 32'h0,        4'hF, 32'h0,        1'b0, 32'hA5C355EF};
        vt[17] = '{1'b1, 1'b1, 12'h014, 3'b000, 32'hFFFFFF80, 4'h1, 32'h80808080, 1'b0, 32'h00000000};
        vt[18] = '{1'b1, 1'b0, 12'h014, 3'b000, 32'h0,        4'h1, 32'h0,        1'b0, 32'hFFFFFF80};
        vt[19] = '{1'b0, 1'b0, 12'h014, 3'b100, 32'h0,        4'h1, 32'h0,        1'b0, 32'h00000080};
        vt[20] = '{1'b1, 1'b1, 12'h016, 3'b010, 32'h0,        4'h0, 32'h0,        1'b1, 32'h00000000};
        vt[21] = '{1'b1, 1'b0, 12'h017, 3'b001, 32'h0,        4'h0, 32'h0,        1'b1, 32'h00000000};

        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_size = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_size = '0; p1_wdata = '0; p1_lock = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
        check("reset err", 32'({p0_err, p1_err}), 32'd0);
        check("reset rdata0", p0_rdata, 32'h0);
        check("reset rdata1", p1_rdata, 32'h0);
        check("reset strobes", 32'({ram_read, ram_write, ram_size}), 32'd0);

        for (int i = 0; i < 22; i++) run_vec(i);

        // Back-to-back loads: second grant overlaps the first response.
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 12'h010, 3'b010, 32'h0);
        #3 check("pipe gnt0", 32'(p0_gnt), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 12'h011, 3'b100, 32'h0);
        #1;
        check("pipe gnt1", 32'(p0_gnt), 32'd1);
        check("pipe rvalid1", 32'(p0_rvalid), 32'd1);
        check("pipe rdata1", p0_rdata, 32'hA5C355EF);
        @(posedge clk); #1;
        idle();
        #1;
        check("pipe rvalid2", 32'(p0_rvalid), 32'd1);
        check("pipe rdata2", p0_rdata, 32'h00000055);

        // Store presented while reset is held: no strobe, no response.
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 1'b1, 12'h010, 3'b010, 32'h0);
        #3 check("rst write strobe", 32'(ram_write), 32'd0);
        @(posedge clk); #1;
        idle();
        rst = 1'b0;
        #1 check("rst rvalid", 32'(p0_rvalid), 32'd0);
        run_vec(12);

        // Contention: both request every cycle.
        do_reset();
        drive(1'b0, 1'b0, 12'h010, 3'b010, 32'h0);
        drive(1'b1, 1'b0, 12'h014, 3'b000, 32'h0);
        for (int c = 0; c < 6; c++) begin
            #3;
            check($sformatf("cont%0d gnt0", c), 32'(p0_gnt), 32'(RR ? (c % 2 == 0) : 1'b1));
            check($sformatf("cont%0d gnt1", c), 32'(p1_gnt), 32'(RR ? (c % 2 == 1) : 1'b0));
            @(posedge clk); #1;
        end
        idle();

        // Lock limit: p1 locks alone, then p0 contends continuously.
        do_reset();
        for (int c = 0; c < 17; c++) begin
            if (c == 0) begin
                drive(1'b1, 1'b0, 12'h014, 3'b000, 32'h0);
                p1_lock = 1'b1;
            end
            if (c == 1) drive(1'b0, 1'b0, 12'h010, 3'b010, 32'h0);
            #3;
            check($sformatf("lock%0d gnt1", c), 32'(p1_gnt), 32'(RR ? (c < 16) : (c == 0)));
            check($sformatf("lock%0d gnt0", c), 32'(p0_gnt), 32'(RR ? (c == 16) : (c >= 1)));
            @(posedge clk); #1;
        end
        idle();
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
